cac_wr_seq: RTL and testbench

- Cache data write sequencer for the four-way cache data slices.
- Shares the cache data write port between two requesters: memory refill (a four-word quad) and CPU store (a single word).
- Drives way select, write strobes, the word address (bits 34:35), write data and the generated parity bit to every data slice.
- Sits between the MBox fill path and the cache data boards.

---
 rtl/cac_wr_seq.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cac_wr_seq.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cac_wr_seq.sv
// cac_wr_seq: cache data write sequencer for the four-way data slices.
// Shares one data write port between a quad memory refill and a CPU store.
//
// Optional build macro: CAC_FILL_PAR_CHK_EN
//   defined   - every accepted refill word has its received parity checked;
//               a mismatch sets csh_par_err_h (sticky until reset).
//   undefined - mem_par_h is ignored, csh_par_err_h is tied low.
//
// Ports:
//   clk_h, reset_h       clock, synchronous active-high reset
//   fill_req_h           start a quad refill (taken only in IDLE)
//   fill_way_h           refill target way
//   fill_wd_h            first refill word address (bits 34:35)
//   mem_vld_h            refill word valid on mem_to_cache_h
//   mem_to_cache_h       refill data word
//   mem_par_h            parity received with the refill word
//   store_req_h          CPU store request, held until store_ack_h
//   store_way_h          store way
//   store_wd_h           store word address
//   store_data_h         store data
//   store_ack_h          one-cycle pulse after the store write
//   fill_busy_h          refill in progress
//   fill_done_h          one-cycle pulse after the fourth refill write
//   fill_ovr_h           sticky: a refill word was lost
//   csh_par_err_h        sticky: refill parity mismatch
//   csh_sel_l            active-low way select
//   cache_wr_l           active-low way write strobe
//   cache_adr_wd_h       word address (bits 34:35)
//   cache_wdata_h        write data
//   csh_par_bit_h        odd parity bit of cache_wdata_h

module cac_wr_seq #(
    parameter int DATA_W   = 36,
    parameter int NWAYS    = 4,
    parameter int WR_PULSE = 1
) (
    input  logic              clk_h,
    input  logic              reset_h,
    input  logic              fill_req_h,
    input  logic [1:0]        fill_way_h,
    input  logic [1:0]        fill_wd_h,
    input  logic              mem_vld_h,
    input  logic [DATA_W-1:0] mem_to_cache_h,
    input  logic              mem_par_h,
    input  logic              store_req_h,
    input  logic [1:0]        store_way_h,
    input  logic [1:0]        store_wd_h,
    input  logic [DATA_W-1:0] store_data_h,
    output logic              store_ack_h,
    output logic              fill_busy_h,
    output logic              fill_done_h,
    output logic              fill_ovr_h,
    output logic              csh_par_err_h,
    output logic [NWAYS-1:0]  csh_sel_l,
    output logic [NWAYS-1:0]  cache_wr_l,
    output logic [1:0]        cache_adr_wd_h,
    output logic [DATA_W-1:0] cache_wdata_h,
    output logic              csh_par_bit_h
);

    typedef enum logic [2:0] {
        IDLE,
        ST_SETUP,
        ST_WR,
        F_WAIT,
        F_SETUP,
        F_WR
    } state_t;

    localparam logic [1:0] PULSE_END = 2'(WR_PULSE - 1);

    state_t state_q;
    state_t state_d;

    // write-port datapath: what the slices see during SETUP/WR
    logic [1:0]        way_q;
    logic [1:0]        adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        pulse_q;

    // refill context
    logic [1:0]        fill_way_q;
    logic [1:0]        fill_wd_q;
    logic [1:0]        nwords_q;

    // one-entry holding buffer for words arriving outside F_WAIT
    logic              hb_full_q;
    logic [DATA_W-1:0] hb_data_q;

    logic              ack_q;
    logic              done_q;
    logic              ovr_q;

    logic              busy;
    logic              in_wait;
    logic              wr_done;
    logic              last_word;
    logic              start_fill;
    logic              start_store;
    logic              f_take;
    logic              fill_end;
    logic              mem_direct;
    logic              mem_to_hb;
    logic              mem_drop;
    logic [NWAYS-1:0]  way_oh;

    assign busy      = (state_q == F_WAIT) ||
                       (state_q == F_SETUP) ||
                       (state_q == F_WR);
    assign in_wait   = (state_q == F_WAIT);
    assign wr_done   = (pulse_q == PULSE_END);
    assign last_word = (nwords_q == 2'd3);
    assign fill_end  = (state_q == F_WR) && wr_done && last_word;

    assign start_fill = (state_q == IDLE) && fill_req_h;

    // The ack cycle is still IDLE while the requester drops its
    // request, so a store is not restarted while store_ack_h is high.
    assign start_store = (state_q == IDLE) && !fill_req_h &&
                         store_req_h && !ack_q;

    // The buffered word is always older, so it goes first.
    assign f_take = in_wait && (hb_full_q || mem_vld_h);

    assign mem_direct = in_wait && !hb_full_q && mem_vld_h;

    // A word goes to the buffer when arriving outside F_WAIT with the
    // buffer free, or in F_WAIT while the buffered word is being taken.
    assign mem_to_hb = busy && mem_vld_h &&
                       ((in_wait && hb_full_q) ||
                        (!in_wait && !hb_full_q));

    assign mem_drop = busy && mem_vld_h && !in_wait && hb_full_q;

    assign way_oh = {{(NWAYS-1){1'b0}}, 1'b1} << way_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fill_req_h) begin
                    state_d = F_WAIT;
                end else if (start_store) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (wr_done) begin
                    state_d = IDLE;
                end
            end
            F_WAIT: begin
                if (f_take) begin
                    state_d = F_SETUP;
                end
            end
            F_SETUP: begin
                state_d = F_WR;
            end
            F_WR: begin
                if (wr_done) begin
                    state_d = last_word ? IDLE : F_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        csh_sel_l  = '1;
        cache_wr_l = '1;
        unique case (1'b1)
            (state_q == ST_SETUP) || (state_q == F_SETUP): begin
                csh_sel_l = ~way_oh;
            end
            (state_q == ST_WR) || (state_q == F_WR): begin
                csh_sel_l  = ~way_oh;
                cache_wr_l = ~way_oh;
            end
            default: begin
            end
        endcase
    end

    assign cache_adr_wd_h = adr_q;
    assign cache_wdata_h  = wdata_q;
    assign csh_par_bit_h  = ~^wdata_q;
    assign store_ack_h    = ack_q;
    assign fill_done_h    = done_q;
    assign fill_busy_h    = busy;
    assign fill_ovr_h     = ovr_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            way_q      <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            pulse_q    <= '0;
            fill_way_q <= '0;
            fill_wd_q  <= '0;
            nwords_q   <= '0;
            hb_full_q  <= 1'b0;
            hb_data_q  <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ack_q  <= (state_q == ST_WR) && wr_done;
            done_q <= fill_end;

            if ((state_q == ST_WR) || (state_q == F_WR)) begin
                pulse_q <= pulse_q + 2'd1;
            end else begin
                pulse_q <= '0;
            end

            if (start_fill) begin
                fill_way_q <= fill_way_h;
                fill_wd_q  <= fill_wd_h;
                nwords_q   <= '0;
            end

            // Data only changes when entering a SETUP state, so the
            // parity bit never moves under an active strobe.
            if (start_store) begin
                way_q   <= store_way_h;
                adr_q   <= store_wd_h;
                wdata_q <= store_data_h;
            end

            if (f_take) begin
                way_q   <= fill_way_q;
                adr_q   <= fill_wd_q;
                wdata_q <= hb_full_q ? hb_data_q : mem_to_cache_h;
            end

            if ((state_q == F_WR) && wr_done) begin
                fill_wd_q <= fill_wd_q + 2'd1;
                nwords_q  <= nwords_q + 2'd1;
            end

            if (mem_to_hb) begin
                hb_full_q <= 1'b1;
                hb_data_q <= mem_to_cache_h;
            end else if (f_take) begin
                hb_full_q <= 1'b0;
            end

            // Anything still buffered at quad end is surplus.
            if (fill_end) begin
                hb_full_q <= 1'b0;
            end

            if (mem_drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

`ifdef CAC_FILL_PAR_CHK_EN
    logic mem_accept;
    logic par_err_q;

    assign mem_accept = mem_direct || mem_to_hb;

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            par_err_q <= 1'b0;
        end else if (mem_accept && (mem_par_h != ~^mem_to_cache_h)) begin
            par_err_q <= 1'b1;
        end
    end

    assign csh_par_err_h = par_err_q;
`else
    logic unused_par;

    assign unused_par    = mem_par_h ^ mem_direct;
    assign csh_par_err_h = 1'b0;
`endif

endmodule

// File: tb/tb_cac_wr_seq.sv
// tb_cac_wr_seq: scoreboard bench for cac_wr_seq.
// Expected writes are queued by stimulus, popped by a negedge monitor.

module tb_cac_wr_seq;

    localparam int DW = 36;

    logic          clk_h = 1'b0;
    logic          reset_h;
    logic          fill_req_h;
    logic [1:0]    fill_way_h;
    logic [1:0]    fill_wd_h;
    logic          mem_vld_h;
    logic [DW-1:0] mem_to_cache_h;
    logic          mem_par_h;
    logic          store_req_h;
    logic [1:0]    store_way_h;
    logic [1:0]    store_wd_h;
    logic [DW-1:0] store_data_h;
    logic          store_ack_h;
    logic          fill_busy_h;
    logic          fill_done_h;
    logic          fill_ovr_h;
    logic          csh_par_err_h;
    logic [3:0]    csh_sel_l;
    logic [3:0]    cache_wr_l;
    logic [1:0]    cache_adr_wd_h;
    logic [DW-1:0] cache_wdata_h;
    logic          csh_par_bit_h;

    cac_wr_seq #(
        .DATA_W   (DW),
        .NWAYS    (4),
        .WR_PULSE (1)
    ) dut (
        .clk_h          (clk_h),
        .reset_h        (reset_h),
        .fill_req_h     (fill_req_h),
        .fill_way_h     (fill_way_h),
        .fill_wd_h      (fill_wd_h),
        .mem_vld_h      (mem_vld_h),
        .mem_to_cache_h (mem_to_cache_h),
        .mem_par_h      (mem_par_h),
        .store_req_h    (store_req_h),
        .store_way_h    (store_way_h),
        .store_wd_h     (store_wd_h),
        .store_data_h   (store_data_h),
        .store_ack_h    (store_ack_h),
        .fill_busy_h    (fill_busy_h),
        .fill_done_h    (fill_done_h),
        .fill_ovr_h     (fill_ovr_h),
        .csh_par_err_h  (csh_par_err_h),
        .csh_sel_l      (csh_sel_l),
        .cache_wr_l     (cache_wr_l),
        .cache_adr_wd_h (cache_adr_wd_h),
        .cache_wdata_h  (cache_wdata_h),
        .csh_par_bit_h  (csh_par_bit_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic [1:0]    way;
        logic [1:0]    adr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt  = 0;
    int done_cnt = 0;
    int exp_ack  = 0;
    int exp_done = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int done_cyc = 0;
    logic exp_perr = 1'b0;

    logic [3:0] prev_wr   = 4'hF;
    logic       prev_par  = 1'b1;
    logic       prev_ack  = 1'b0;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic par_of(input logic [DW-1:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic [DW-1:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    function automatic int way_of(input logic [3:0] wr_l);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (!wr_l[i]) w = i;
        end
        return w;
    endfunction

    task automatic push_exp(input logic [1:0] way, input logic [1:0] adr,
                            input logic [DW-1:0] data);
        wr_t e;
        e.way  = way;
        e.adr  = adr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_h) begin
        wr_t e;
        cyc++;
        if (!reset_h) begin
            chk("sel_onehot",
                ($countones(~csh_sel_l) <= 1) &&
                ((~cache_wr_l & csh_sel_l) == 4'h0), 1);
            if (csh_par_bit_h != prev_par) begin
                chk("par_stable",
                    (prev_wr == 4'hF) && (cache_wr_l == 4'hF), 1);
            end
            if ((cache_wr_l != 4'hF) && (prev_wr == 4'hF)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_way", way_of(cache_wr_l), e.way);
                    chk("wr_adr", cache_adr_wd_h, e.adr);
                    chk("wr_data", cache_wdata_h, e.data);
                    chk("wr_par", csh_par_bit_h, par_of(e.data));
                end
            end
            if (store_ack_h) begin
                chk("ack_pulse", prev_ack, 0);
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (fill_done_h) begin
                chk("done_pulse", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_wr   = cache_wr_l;
        prev_par  = csh_par_bit_h;
        prev_ack  = store_ack_h;
        prev_done = fill_done_h;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic wait_cnt(input bit is_ack, input int tgt);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_h);
            #1;
            if ((is_ack ? ack_cnt : done_cnt) >= tgt) break;
        end
        @(posedge clk_h);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] d, input bit ok);
        mem_to_cache_h = d;
        mem_par_h      = ok ? par_of(d) : ~par_of(d);
        mem_vld_h      = 1'b1;
        tick();
        mem_vld_h      = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] way, input logic [1:0] wd,
                            input logic [DW-1:0] data);
        push_exp(way, wd, data);
        exp_ack++;
        store_way_h  = way;
        store_wd_h   = wd;
        store_data_h = data;
        store_req_h  = 1'b1;
        wait_cnt(1'b1, exp_ack);
        store_req_h  = 1'b0;
        chk("store_ack", ack_cnt, exp_ack);
        tick();
    endtask

    task automatic do_fill(input logic [1:0] way, input logic [1:0] st,
                           input int gmin, input int gmax, input int bad);
        logic [DW-1:0] d;
        logic [1:0]    a;
        exp_done++;
        fill_way_h = way;
        fill_wd_h  = st;
        fill_req_h = 1'b1;
        tick();
        fill_req_h = 1'b0;
        a = st;
        for (int i = 0; i < 4; i++) begin
            d = rnd36();
            push_exp(way, a, d);
            a = a + 2'd1;
            feed(d, i != bad);
            repeat ($urandom_range(gmax, gmin) - 1) tick();
        end
        wait_cnt(1'b0, exp_done);
        chk("fill_done", done_cnt, exp_done);
        chk("fill_q_empty", exp_q.size(), 0);
        chk("fill_busy_clr", fill_busy_h, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1, d2, d3, d4, sd;

        reset_h        = 1'b1;
        fill_req_h     = 1'b0;
        fill_way_h     = '0;
        fill_wd_h      = '0;
        mem_vld_h      = 1'b0;
        mem_to_cache_h = '0;
        mem_par_h      = 1'b0;
        store_req_h    = 1'b0;
        store_way_h    = '0;
        store_wd_h     = '0;
        store_data_h   = '0;

        repeat (3) @(posedge clk_h);
        #1;
        reset_h = 1'b0;
        @(negedge clk_h);
        chk("rst_wr", cache_wr_l, 4'hF);
        chk("rst_sel", csh_sel_l, 4'hF);
        chk("rst_par", csh_par_bit_h, 1);
        chk("rst_ack", store_ack_h, 0);
        chk("rst_busy", fill_busy_h, 0);
        chk("rst_done", fill_done_h, 0);
        chk("rst_ovr", fill_ovr_h, 0);
        chk("rst_perr", csh_par_err_h, 0);
        chk("rst_adr", cache_adr_wd_h, 0);
        chk("rst_data", cache_wdata_h, 0);
        @(posedge clk_h);
        #1;

        // directed store: way 2, word 3, cycle by cycle
        push_exp(2'd2, 2'd3, 36'o123456701234);
        exp_ack++;
        store_way_h  = 2'd2;
        store_wd_h   = 2'd3;
        store_data_h = 36'o123456701234;
        store_req_h  = 1'b1;
        @(posedge clk_h);
        @(negedge clk_h);
        chk("st_setup_sel", csh_sel_l, 4'b1011);
        chk("st_setup_wr", cache_wr_l, 4'hF);
        @(negedge clk_h);
        chk("st_wr_strobe", cache_wr_l, 4'b1011);
        chk("st_wr_sel", csh_sel_l, 4'b1011);
        chk("st_wr_par", csh_par_bit_h, 0);
        @(negedge clk_h);
        chk("st_ack", store_ack_h, 1);
        chk("st_sel_rel", csh_sel_l, 4'hF);
        @(posedge clk_h);
        #1;
        store_req_h = 1'b0;
        @(negedge clk_h);
        chk("st_ack_clr", store_ack_h, 0);
        @(posedge clk_h);
        #1;

        // directed refill: way 1, start word 2, words 3 cycles apart
        do_fill(2'd1, 2'd2, 3, 3, -1);
        chk("fill_ovr_clean", fill_ovr_h, 0);
        chk("fill_perr_clean", csh_par_err_h, 0);

        // refill and store requested in the same cycle
        exp_done++;
        exp_ack++;
        sd = rnd36();
        fill_way_h   = 2'd0;
        fill_wd_h    = 2'd1;
        store_way_h  = 2'd3;
        store_wd_h   = 2'd0;
        store_data_h = sd;
        fill_req_h   = 1'b1;
        store_req_h  = 1'b1;
        tick();
        fill_req_h = 1'b0;
        d0 = rnd36();
        push_exp(2'd0, 2'd1, d0);
        feed(d0, 1'b1);
        repeat (2) tick();
        d1 = rnd36();
        push_exp(2'd0, 2'd2, d1);
        feed(d1, 1'b1);
        repeat (2) tick();
        d2 = rnd36();
        push_exp(2'd0, 2'd3, d2);
        feed(d2, 1'b1);
        repeat (2) tick();
        d3 = rnd36();
        push_exp(2'd0, 2'd0, d3);
        feed(d3, 1'b1);
        push_exp(2'd3, 2'd0, sd);
        wait_cnt(1'b1, exp_ack);
        store_req_h = 1'b0;
        chk("both_ack", ack_cnt, exp_ack);
        chk("both_done", done_cnt, exp_done);
        chk("ack_after_done", ack_cyc > done_cyc, 1);
        chk("both_q_empty", exp_q.size(), 0);
        tick();

        // refill with one corrupted parity bit on the third word
        do_fill(2'd0, 2'd1, 3, 3, 2);
`ifdef CAC_FILL_PAR_CHK_EN
        exp_perr = 1'b1;
`endif
        chk("par_err", csh_par_err_h, exp_perr);

        // random mix of stores and refills
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_store(2'($urandom), 2'($urandom), rnd36());
            end else begin
                do_fill(2'($urandom), 2'($urandom), 2, 5, -1);
            end
        end
        chk("rand_par_err", csh_par_err_h, exp_perr);
        chk("rand_ovr", fill_ovr_h, 0);

        // reset in the middle of a refill
        d0 = rnd36();
        d1 = rnd36();
        fill_way_h = 2'd3;
        fill_wd_h  = 2'd0;
        fill_req_h = 1'b1;
        tick();
        fill_req_h = 1'b0;
        push_exp(2'd3, 2'd0, d0);
        feed(d0, 1'b1);
        repeat (2) tick();
        feed(d1, 1'b1);
        @(negedge clk_h);
        chk("mid_pre_sel", csh_sel_l, 4'b0111);
        reset_h = 1'b1;
        @(posedge clk_h);
        @(negedge clk_h);
        chk("mid_sel", csh_sel_l, 4'hF);
        chk("mid_wr", cache_wr_l, 4'hF);
        chk("mid_busy", fill_busy_h, 0);
        @(posedge clk_h);
        #1;
        reset_h  = 1'b0;
        exp_perr = 1'b0;
        repeat (6) tick();
        chk("mid_no_done", done_cnt, exp_done);
        chk("mid_no_ack", ack_cnt, exp_ack);
        chk("mid_q_empty", exp_q.size(), 0);
        chk("mid_perr_clr", csh_par_err_h, exp_perr);

        // overrun: three back-to-back words, the third is lost
        exp_done++;
        d0 = rnd36();
        d1 = rnd36();
        d2 = rnd36();
        d3 = rnd36();
        d4 = rnd36();
        fill_way_h = 2'd1;
        fill_wd_h  = 2'd2;
        fill_req_h = 1'b1;
        tick();
        fill_req_h = 1'b0;
        push_exp(2'd1, 2'd2, d0);
        push_exp(2'd1, 2'd3, d1);
        push_exp(2'd1, 2'd0, d3);
        push_exp(2'd1, 2'd1, d4);
        chk("ovr_before", fill_ovr_h, 0);
        feed(d0, 1'b1);
        feed(d1, 1'b1);
        feed(d2, 1'b1);
        chk("ovr_set", fill_ovr_h, 1);
        repeat (2) tick();
        feed(d3, 1'b1);
        repeat (2) tick();
        feed(d4, 1'b1);
        wait_cnt(1'b0, exp_done);
        chk("ovr_done", done_cnt, exp_done);
        chk("ovr_q_empty", exp_q.size(), 0);
        chk("ovr_sticky", fill_ovr_h, 1);

        // mem_vld_h while idle is ignored
        feed(rnd36(), 1'b1);
        repeat (4) tick();
        chk("idle_vld_q", exp_q.size(), 0);
        chk("idle_vld_busy", fill_busy_h, 0);

        // reset clears the sticky flags
        reset_h = 1'b1;
        repeat (2) tick();
        reset_h = 1'b0;
        @(negedge clk_h);
        chk("end_ovr_clr", fill_ovr_h, 0);
        chk("end_perr_clr", csh_par_err_h, 0);
        chk("end_acks", ack_cnt, exp_ack);
        chk("end_dones", done_cnt, exp_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
